// File: rtl/activity_window_analyzer.sv
// Turns free-running activity counters into per-window deltas and raises sticky
// threshold alarms; results and alarms update one cycle after each window capture.
module activity_window_analyzer #(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned FSM_MIN       = 8,
  parameter int unsigned PCW_MAX       = 512,
  parameter int unsigned REC_MAX       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_alarm,
  input  logic [31:0] fsm_count_in,
  input  logic [31:0] pcw_count_in,
  input  logic [31:0] rec_count_in,
  output logic [31:0] fsm_delta,
  output logic [31:0] pcw_delta,
  output logic [31:0] rec_delta,
  output logic        window_valid,
  output logic [15:0] window_count,
  output logic        fsm_stall_alarm,
  output logic        pcw_alarm,
  output logic        rec_alarm,
  output logic        any_alarm
);

  localparam logic [15:0] TIMER_LAST = 16'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    EVAL    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_timer;
  logic [31:0] r_fsm_base;
  logic [31:0] r_pcw_base;
  logic [31:0] r_rec_base;
  logic [31:0] r_fsm_delta;
  logic [31:0] r_pcw_delta;
  logic [31:0] r_rec_delta;
  logic        r_window_valid;
  logic [15:0] r_window_count;
  logic        r_fsm_alarm;
  logic        r_pcw_alarm;
  logic        r_rec_alarm;
  logic        r_any_alarm;

  logic        w_eval;
  logic        w_fsm_alarm_nxt;
  logic        w_pcw_alarm_nxt;
  logic        w_rec_alarm_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // CAPTURE and EVAL always complete once entered, regardless of enable.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = RUN;
      end
      RUN: begin
        if (!enable)                   w_state_nxt = IDLE;
        else if (r_timer == TIMER_LAST) w_state_nxt = CAPTURE;
      end
      CAPTURE: w_state_nxt = EVAL;
      EVAL:    w_state_nxt = enable ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A set in EVAL beats a coincident clear for the same alarm.
  always_comb begin
    w_eval          = (r_state == EVAL);
    w_fsm_alarm_nxt = (r_fsm_alarm & ~clear_alarm) | (w_eval & (r_fsm_delta < 32'(FSM_MIN)));
    w_pcw_alarm_nxt = (r_pcw_alarm & ~clear_alarm) | (w_eval & (r_pcw_delta > 32'(PCW_MAX)));
    w_rec_alarm_nxt = (r_rec_alarm & ~clear_alarm) | (w_eval & (r_rec_delta > 32'(REC_MAX)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer        <= '0;
      r_fsm_base     <= '0;
      r_pcw_base     <= '0;
      r_rec_base     <= '0;
      r_fsm_delta    <= '0;
      r_pcw_delta    <= '0;
      r_rec_delta    <= '0;
      r_window_valid <= 1'b0;
      r_window_count <= '0;
      r_fsm_alarm    <= 1'b0;
      r_pcw_alarm    <= 1'b0;
      r_rec_alarm    <= 1'b0;
      r_any_alarm    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_fsm_base <= fsm_count_in;
            r_pcw_base <= pcw_count_in;
            r_rec_base <= rec_count_in;
            r_timer    <= '0;
          end
        end
        RUN: begin
          r_timer <= r_timer + 16'd1;
        end
        CAPTURE: begin
          // Modulo-2^32 subtraction keeps deltas correct across upstream wrap.
          r_fsm_delta <= fsm_count_in - r_fsm_base;
          r_pcw_delta <= pcw_count_in - r_pcw_base;
          r_rec_delta <= rec_count_in - r_rec_base;
          r_fsm_base  <= fsm_count_in;
          r_pcw_base  <= pcw_count_in;
          r_rec_base  <= rec_count_in;
        end
        EVAL: begin
          r_timer <= '0;
          if (r_window_count != 16'hFFFF) r_window_count <= r_window_count + 16'd1;
        end
        default: ;
      endcase
      r_window_valid <= w_eval;
      r_fsm_alarm    <= w_fsm_alarm_nxt;
      r_pcw_alarm    <= w_pcw_alarm_nxt;
      r_rec_alarm    <= w_rec_alarm_nxt;
      r_any_alarm    <= w_fsm_alarm_nxt | w_pcw_alarm_nxt | w_rec_alarm_nxt;
    end
  end

  assign fsm_delta       = r_fsm_delta;
  assign pcw_delta       = r_pcw_delta;
  assign rec_delta       = r_rec_delta;
  assign window_valid    = r_window_valid;
  assign window_count    = r_window_count;
  assign fsm_stall_alarm = r_fsm_alarm;
  assign pcw_alarm       = r_pcw_alarm;
  assign rec_alarm       = r_rec_alarm;
  assign any_alarm       = r_any_alarm;

endmodule

// File: tb/tb_activity_window_analyzer.sv
// Directed bench for activity_window_analyzer with a 16-cycle window; a second
// instance with PCW_MAX one higher checks the pcw threshold boundary.
module tb_activity_window_analyzer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear_alarm;
  logic [31:0] fsm_cnt;
  logic [31:0] pcw_cnt;
  logic [31:0] rec_cnt;
  logic [31:0] fsm_inc;

  logic [31:0] fsm_delta, pcw_delta, rec_delta;
  logic        window_valid;
  logic [15:0] window_count;
  logic        fsm_stall_alarm, pcw_alarm, rec_alarm, any_alarm;

  logic [31:0] b_fsm_delta, b_pcw_delta, b_rec_delta;
  logic        b_window_valid;
  logic [15:0] b_window_count;
  logic        b_fsm_stall_alarm, b_pcw_alarm, b_rec_alarm, b_any_alarm;

  int checks = 0;
  int errors = 0;
  int n;
  int vld_seen;

  always #5 clk = ~clk;

  activity_window_analyzer #(
    .WINDOW_CYCLES(16), .FSM_MIN(8), .PCW_MAX(31), .REC_MAX(64)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_alarm(clear_alarm),
    .fsm_count_in(fsm_cnt), .pcw_count_in(pcw_cnt), .rec_count_in(rec_cnt),
    .fsm_delta(fsm_delta), .pcw_delta(pcw_delta), .rec_delta(rec_delta),
    .window_valid(window_valid), .window_count(window_count),
    .fsm_stall_alarm(fsm_stall_alarm), .pcw_alarm(pcw_alarm),
    .rec_alarm(rec_alarm), .any_alarm(any_alarm)
  );

  activity_window_analyzer #(
    .WINDOW_CYCLES(16), .FSM_MIN(8), .PCW_MAX(32), .REC_MAX(64)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .clear_alarm(clear_alarm),
    .fsm_count_in(fsm_cnt), .pcw_count_in(pcw_cnt), .rec_count_in(rec_cnt),
    .fsm_delta(b_fsm_delta), .pcw_delta(b_pcw_delta), .rec_delta(b_rec_delta),
    .window_valid(b_window_valid), .window_count(b_window_count),
    .fsm_stall_alarm(b_fsm_stall_alarm), .pcw_alarm(b_pcw_alarm),
    .rec_alarm(b_rec_alarm), .any_alarm(b_any_alarm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The fsm counter advances by fsm_inc just after every rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    fsm_cnt = fsm_cnt + fsm_inc;
  endtask

  // Returns the number of edges until window_valid is seen, or 99 on timeout.
  task automatic wait_valid(output int cnt);
    cnt = 99;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (window_valid === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear_alarm = 1'b0;
    fsm_cnt = 32'd100; pcw_cnt = 32'd0; rec_cnt = 32'd0; fsm_inc = 32'd1;
    tick(); tick();
    chk("rst_fsm_delta", fsm_delta, 32'd0);
    chk("rst_window_count", 32'(window_count), 32'd0);
    chk("rst_valid_alarms", {28'd0, window_valid, fsm_stall_alarm, pcw_alarm, any_alarm}, 32'd0);
    reset = 1'b0;
    tick();

    // Window 1: first result 18 edges after the enabling edge.
    enable = 1'b1;
    tick();
    wait_valid(n);
    chk("t1_latency", n, 32'd18);
    chk("t1_fsm_delta", fsm_delta, 32'd17);
    chk("t1_pcw_delta", pcw_delta, 32'd0);
    chk("t1_window_count", 32'(window_count), 32'd1);
    chk("t1_any_alarm", 32'(any_alarm), 32'd0);
    tick();
    chk("t1_valid_pulse", 32'(window_valid), 32'd0);
    wait_valid(n);
    chk("t1_period", n, 32'd17);
    chk("t1_fsm_delta2", fsm_delta, 32'd18);
    chk("t1_window_count2", 32'(window_count), 32'd2);

    // Stall: counter frozen, spillover window then a fully idle window.
    fsm_inc = 32'd0;
    wait_valid(n);
    chk("t2_fsm_delta_spill", fsm_delta, 32'd2);
    chk("t2_stall_alarm_a", 32'(fsm_stall_alarm), 32'd1);
    wait_valid(n);
    chk("t2_fsm_delta_zero", fsm_delta, 32'd0);
    chk("t2_stall_alarm_b", 32'(fsm_stall_alarm), 32'd1);
    chk("t2_any_alarm", 32'(any_alarm), 32'd1);
    fsm_inc = 32'd1;
    wait_valid(n);
    chk("t2_fsm_delta_healthy", fsm_delta, 32'd16);
    chk("t2_stall_sticky", 32'(fsm_stall_alarm), 32'd1);
    chk("t2_window_count", 32'(window_count), 32'd5);
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    chk("t2_cleared", {29'd0, fsm_stall_alarm, pcw_alarm, any_alarm}, 32'd0);

    // pcw wrap: baseline near the top, counter wraps before capture.
    enable = 1'b0;
    tick();
    pcw_cnt = 32'hFFFF_FFF0;
    enable = 1'b1;
    tick();
    pcw_cnt = 32'h0000_0010;
    wait_valid(n);
    chk("t3_latency", n, 32'd18);
    chk("t3_pcw_delta", pcw_delta, 32'h20);
    chk("t3_fsm_delta", fsm_delta, 32'd17);
    chk("t3_pcw_alarm_max31", 32'(pcw_alarm), 32'd1);
    chk("t3_pcw_alarm_max32", 32'(b_pcw_alarm), 32'd0);
    chk("t3_window_count", 32'(window_count), 32'd6);

    // rec boundary, then one over with a clear landing on the EVAL cycle.
    rec_cnt = 32'd64;
    wait_valid(n);
    chk("t4_rec_delta_eq", rec_delta, 32'd64);
    chk("t4_rec_alarm_eq", 32'(rec_alarm), 32'd0);
    chk("t4_fsm_delta", fsm_delta, 32'd18);
    rec_cnt = 32'd129;
    repeat (17) tick();
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    chk("t4_valid_on_clear", 32'(window_valid), 32'd1);
    chk("t4_rec_delta_over", rec_delta, 32'd65);
    chk("t4_rec_alarm_set_wins", 32'(rec_alarm), 32'd1);
    chk("t4_pcw_alarm_cleared", 32'(pcw_alarm), 32'd0);
    chk("t4_any_alarm", 32'(any_alarm), 32'd1);

    // Abort a window at timer=5; aborted counts must not appear later.
    repeat (5) tick();
    enable = 1'b0;
    vld_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (window_valid === 1'b1) vld_seen++;
      if (i == 3) begin
        rec_cnt = rec_cnt + 32'd1000;
        pcw_cnt = pcw_cnt + 32'd5000;
      end
    end
    chk("t5_no_valid", vld_seen, 32'd0);
    chk("t5_rec_delta_hold", rec_delta, 32'd65);
    chk("t5_window_count_hold", 32'(window_count), 32'd8);
    enable = 1'b1;
    tick();
    wait_valid(n);
    chk("t5_latency", n, 32'd18);
    chk("t5_fsm_delta", fsm_delta, 32'd17);
    chk("t5_rec_delta", rec_delta, 32'd0);
    chk("t5_pcw_delta", pcw_delta, 32'd0);
    chk("t5_pcw_alarm", 32'(pcw_alarm), 32'd0);
    chk("t5_window_count", 32'(window_count), 32'd9);

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rec_alarm", 32'(rec_alarm), 32'd0);
    chk("t6_any_alarm", 32'(any_alarm), 32'd0);
    chk("t6_window_count", 32'(window_count), 32'd0);
    chk("t6_fsm_delta", fsm_delta, 32'd0);
    enable = 1'b0;
    tick();
    reset = 1'b0;
    vld_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (window_valid === 1'b1) vld_seen++;
    end
    chk("t6_idle_no_valid", vld_seen, 32'd0);
    enable = 1'b1;
    tick();
    wait_valid(n);
    chk("t6_latency", n, 32'd18);
    chk("t6_window_count", 32'(window_count), 32'd1);
    chk("t6_fsm_delta_after", fsm_delta, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/activity_window_analyzer.md
Name: activity_window_analyzer

Overview:
Consumes the three free-running activity counters (FSM transitions, PC-write toggles, recovery cycles) and turns them into per-window activity deltas. Every WINDOW_CYCLES cycles it snapshots the counters, subtracts the previous snapshot, and compares each delta against a threshold. Violations raise sticky alarms for the fault-tolerance supervisor. Sits directly downstream of the activity counter block, inside the estimation top.

Parameters:
WINDOW_CYCLES, 1024, window length in cycles (legal range 2 to 2^16)
FSM_MIN, 8, minimum FSM transitions per window; a lower delta means the core is stalled
PCW_MAX, 512, maximum PC-write toggles per window
REC_MAX, 64, maximum recovery-active cycles per window

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  level; analysis runs while high
clear_alarm  input  1  single-cycle pulse; clears all sticky alarms
fsm_count_in  input  32  FSM transition counter from upstream
pcw_count_in  input  32  PC-write toggle counter from upstream
rec_count_in  input  32  recovery cycle counter from upstream
fsm_delta  output  32  FSM transitions in the last completed window
pcw_delta  output  32  PC-write toggles in the last completed window
rec_delta  output  32  recovery cycles in the last completed window
window_valid  output  1  one-cycle pulse when the deltas and alarms update
window_count  output  16  number of completed windows, saturating
fsm_stall_alarm  output  1  sticky; set when fsm_delta < FSM_MIN
pcw_alarm  output  1  sticky; set when pcw_delta > PCW_MAX
rec_alarm  output  1  sticky; set when rec_delta > REC_MAX
any_alarm  output  1  OR of the three alarms, registered

Behaviour:
- Reset (asynchronous): every output is 0. Baselines = 0, timer = 0, state = IDLE.
- States:
  - IDLE: outputs hold their values. When enable=1, go to RUN; at the same edge, capture baselines from the *_count_in inputs and clear the timer.
  - RUN: the timer increments each cycle. If timer == WINDOW_CYCLES-1, go to CAPTURE.
  - CAPTURE: lasts 1 cycle.
    - delta_x <= count_in_x - baseline_x, computed modulo 2^32 so upstream wrap-around still gives the correct delta.
    - baseline_x <= count_in_x.
  - EVAL: lasts 1 cycle.
    - window_valid=1.
    - Compare the registered deltas and set any alarm whose condition holds.
    - window_count++, saturating at 16'hFFFF.
    - Then go to RUN with timer=0 if enable=1; otherwise go to IDLE.
- Timing:
  - The first capture occurs WINDOW_CYCLES+1 edges after the IDLE->RUN edge.
  - Consecutive captures are WINDOW_CYCLES+2 cycles apart.
  - Counts accumulated during CAPTURE/EVAL go into the next window (baseline continuity), so no events are lost.
- enable deasserted in RUN: go to IDLE next edge. The partial window is discarded. Deltas, alarms and window_count hold. Re-enable re-baselines.
- enable deasserted in CAPTURE/EVAL: the window completes normally, then the block goes to IDLE.
- Alarms are sticky, set only in EVAL. clear_alarm clears all alarms on the next edge in any state. If clear_alarm coincides with an EVAL that sets an alarm, the set wins for that alarm; the others clear.
- Boundaries:
  - fsm_delta == FSM_MIN: no alarm.
  - pcw_delta == PCW_MAX: no alarm.
  - rec_delta == REC_MAX: no alarm.
- any_alarm is updated in the same cycle as the individual alarms, i.e. it is registered from their next-state values.
- Upstream counters reset mid-window to a lower value: the modulo subtraction yields a large delta. This is accepted; it may raise pcw_alarm or rec_alarm.

Test Plan:
1. WINDOW_CYCLES=16. Reset, enable=1. fsm count +1 per cycle, pcw +0, rec +0. Required: window_valid first rises 18 cycles after the enable edge, at the EVAL cycle; fsm_delta=17 (cycles RUN..CAPTURE); window_count=1; no alarms.
2. Hold fsm_count_in constant for a full window. Required: fsm_delta=0, fsm_stall_alarm=1, any_alarm=1. Alarms remain set through the following healthy windows until clear_alarm pulses, then read 0.
3. Baseline pcw=32'hFFFF_FFF0, then the counter wraps to 32'h0000_0010 at capture. Required: pcw_delta=32'h20. With PCW_MAX=31, pcw_alarm=1; with PCW_MAX=32, no alarm.
4. rec delta exactly REC_MAX. Required: rec_alarm=0. Next window REC_MAX+1: rec_alarm=1. Assert clear_alarm on that EVAL cycle: rec_alarm stays 1.
5. Drop enable at timer=5 in RUN. Required: IDLE next cycle, no window_valid, deltas and window_count unchanged. Re-enable with counters at new values: the next delta excludes counts from the aborted window.
6. Assert reset mid-RUN with alarms set. Required: all outputs 0 immediately, without waiting for a clock edge. After release, state=IDLE.
